// File: rtl/game_io_pkg.sv
// Shared definitions for the game event reporter.
// Contents: the register word addresses, the bit positions in the event and
// STATUS words, the packed event word type, and a helper that builds an event word.
package game_io_pkg;

  // Register word addresses
  localparam logic [2:0] EVT  = 3'd0;
  localparam logic [2:0] STAT = 3'd1;
  localparam logic [2:0] CTRL = 3'd2;
  localparam logic [2:0] CLR  = 3'd3;
  localparam logic [2:0] FRM  = 3'd4;

  // Event word bit positions
  localparam int EV_VALID_BIT = 31;
  localparam int EV_SHOOT_BIT = 30;
  localparam int EV_WOUND_LSB = 28;
  localparam int EV_TS_LSB    = 0;

  // STATUS bit positions
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;

  typedef struct packed {
    logic        valid;
    logic        shoot;
    logic [1:0]  wound;
    logic [11:0] rsvd;
    logic [15:0] ts;
  } event_word_t;

  function automatic event_word_t make_event(input logic shoot, input logic [1:0] wound,
                                             input logic [15:0] ts);
    event_word_t ev;
    ev.valid = 1'b1;
    ev.shoot = shoot;
    ev.wound = wound;
    ev.rsvd  = '0;
    ev.ts    = ts;
    return ev;
  endfunction

endpackage

// File: rtl/game_event_reporter_if.sv
// Avalon-MM slave bus plus interrupt line of the game event reporter.
// master: CPU/bus side (drives the strobes, address and write data).
// slave : the peripheral (drives readdata and irq).
interface game_event_reporter_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output chipselect, read, write, address, writedata,
                  input  readdata, irq);
  modport slave  (input  chipselect, read, write, address, writedata,
                  output readdata, irq);
endinterface

// File: rtl/game_event_reporter_fifo.sv
// event_fifo: synchronous FIFO with a flush input.
// Ports: clk, reset (async, active high); push/din write an entry; pop releases
// the head entry; flush empties the FIFO and takes priority over push and pop.
// dout is the head entry and is only meaningful when the FIFO is not empty.
// count, count_next, full, empty report the fill level; count_next is the
// level after the current edge.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok, pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/game_event_reporter.sv
// game_event_reporter: Avalon-MM read-side peripheral reporting gameplay events.
// It detects rising shoot edges and wound onsets, timestamps each one with a
// 16-bit frame counter, and queues it in an event FIFO. The CPU drains the
// FIFO through the EVENT register, either by polling or on the level irq.
// Ports: clk, reset (async, active high); bus (Avalon slave: chipselect, read,
// write, address, writedata, readdata with read latency 1, irq); shoot_in,
// wound_in and frame_start come from the display pipeline.
module game_event_reporter
  import game_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int IRQ_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  game_event_reporter_if.slave  bus,
  input  logic                  shoot_in,
  input  logic [1:0]            wound_in,
  input  logic                  frame_start
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(IRQ_THRESH);

  logic        shoot_q_reg;
  logic [1:0]  wound_q_reg;
  logic [15:0] frame_cnt_reg;
  logic        enable_reg, irq_en_reg, overflow_reg;
  logic        overflow_next;

  logic        shoot_ev, wound_ev, push_req, pop_req, clear;
  logic        rd_en, wr_en;
  event_word_t ev_word;
  logic [31:0] head_word, rd_data;
  logic [CNT_W-1:0] count, count_next;
  logic        full, empty;

  assign shoot_ev = shoot_in & ~shoot_q_reg;
  assign wound_ev = (wound_q_reg == 2'd0) & (wound_in != 2'd0);
  assign push_req = enable_reg & (shoot_ev | wound_ev);
  // The timestamp is the current count, so a coincident frame_start is not yet counted.
  assign ev_word  = make_event(shoot_ev, wound_ev ? wound_in : 2'd0, frame_cnt_reg);

  assign rd_en    = bus.chipselect & bus.read;
  assign wr_en    = bus.chipselect & bus.write;
  assign pop_req  = rd_en & (bus.address == EVT);
  assign clear    = wr_en & (bus.address == CLR);

  event_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_req),
    .pop        (pop_req),
    .flush      (clear),
    .din        (ev_word),
    .dout       (head_word),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  // A full FIFO loses the event only when nothing is popped in the same cycle.
  // pop_req is enough here because a full FIFO is never empty.
  assign overflow_next = clear ? 1'b0 : (overflow_reg | (push_req & full & ~pop_req));

  always_comb begin
    rd_data = '0;
    case (bus.address)
      EVT:  rd_data = empty ? 32'd0 : head_word;
      STAT: begin
        rd_data[CNT_W-1:0]   = count;
        rd_data[ST_EMPTY_BIT] = empty;
        rd_data[ST_FULL_BIT]  = full;
        rd_data[ST_OVF_BIT]   = overflow_reg;
      end
      CTRL: rd_data = {30'd0, irq_en_reg, enable_reg};
      FRM:  rd_data = {16'd0, frame_cnt_reg};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shoot_q_reg   <= 1'b0;
      wound_q_reg   <= 2'd0;
      frame_cnt_reg <= '0;
      enable_reg    <= 1'b0;
      irq_en_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      bus.readdata  <= '0;
      bus.irq       <= 1'b0;
    end else begin
      // The edge registers track their inputs even while enable is low.
      shoot_q_reg  <= shoot_in;
      wound_q_reg  <= wound_in;
      if (frame_start) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (wr_en && bus.address == CTRL) begin
        enable_reg <= bus.writedata[0];
        irq_en_reg <= bus.writedata[1];
      end
      overflow_reg <= overflow_next;
      if (rd_en) bus.readdata <= rd_data;
      bus.irq <= irq_en_reg & ((count_next >= THRESH) | overflow_next);
    end
  end

endmodule

// File: tb/tb_game_event_reporter.sv
// Testbench for game_event_reporter. Each read pushes its expected readdata
// onto a scoreboard queue. The entry is popped and compared once the
// registered readdata appears. A vector table drives the FIFO overflow and
// drain sequence, and hand-written sequences cover the remaining corner cases.
module tb_game_event_reporter;
  import game_io_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       shoot_in = 1'b0;
  logic [1:0] wound_in = 2'd0;
  logic       frame_start = 1'b0;
  int         errors = 0;
  int         checks = 0;

  game_event_reporter_if bus ();

  game_event_reporter #(.FIFO_DEPTH(8), .IRQ_THRESH(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .shoot_in    (shoot_in),
    .wound_in    (wound_in),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, got);
    end
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
    sb_t e;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    sb.push_back('{name, exp});
    tick();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    e = sb.pop_front();
    check(e.name, bus.readdata, e.exp);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic do_reset(input string name);
    #2 reset = 1'b1;
    #1;
    check({name, "_rdata"}, bus.readdata, 32'd0);
    check({name, "_irq"}, {31'd0, bus.irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    shoot_in = 1'b0;
    wound_in = 2'd0;
    frame_start = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    frame_start = 1'b1;
    repeat (n) tick();
    frame_start = 1'b0;
  endtask

  task automatic shoot_pulse();
    shoot_in = 1'b1;
    tick();
    shoot_in = 1'b0;
    tick();
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = 3'd0;
    bus.writedata = 32'd0;

    // Reset state
    do_reset("rst0");
    rd(STAT, 32'h0000_0100, "rst_status");
    rd(CTRL, 32'h0, "rst_ctrl");
    rd(FRM,  32'h0, "rst_frame");
    rd(EVT,  32'h0, "rst_event_empty");

    // 1: single shoot at frame 5
    wr(CTRL, 32'h1);
    frames(5);
    shoot_pulse();
    rd(EVT,  32'hC000_0005, "t1_event");
    rd(STAT, 32'h0000_0100, "t1_status");
    rd(3'd7, 32'h0, "t1_unmapped");
    wr(STAT, 32'hFFFF_FFFF);
    wr(FRM,  32'h1234);
    rd(FRM,  32'h5, "t1_frame_ro");
    rd(CTRL, 32'h1, "t1_ctrl");

    // 2: shoot and wound merge; wound change without passing through 0 is ignored
    do_reset("rst2");
    wr(CTRL, 32'h1);
    frames(16);
    shoot_in = 1'b1; wound_in = 2'd2;
    tick();
    shoot_in = 1'b0;
    tick();
    rd(EVT, 32'hE000_0010, "t2_merged");
    wound_in = 2'd1; tick();
    wound_in = 2'd0; tick();
    wound_in = 2'd3; tick();
    wound_in = 2'd0; tick();
    rd(STAT, 32'h0000_0001, "t2_status");
    rd(EVT,  32'hB000_0010, "t2_wound_only");

    // 3: overflow then drain (vector table)
    do_reset("rst3");
    wr(CTRL, 32'h1);
    tbl[0] = '{STAT, 32'h0000_0608};
    for (int i = 1; i <= 8; i++) tbl[i] = '{EVT, 32'hC000_0000 | 32'(i)};
    tbl[9]  = '{EVT,  32'h0};
    tbl[10] = '{STAT, 32'h0000_0500};
    for (int i = 1; i <= 9; i++) begin
      frames(1);
      shoot_pulse();
    end
    for (int i = 0; i < 11; i++) rd(tbl[i].addr, tbl[i].exp, $sformatf("t3_vec%0d", i));

    // 4: push and pop together on a full FIFO, then CLEAR and CLEAR racing a push
    do_reset("rst4");
    wr(CTRL, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      frames(1);
      shoot_pulse();
    end
    shoot_in = 1'b1;
    rd(EVT, 32'hC000_0001, "t4_pushpop_evt");
    shoot_in = 1'b0;
    tick();
    rd(STAT, 32'h0000_0208, "t4_full_no_ovf");
    rd(EVT,  32'hC000_0002, "t4_next_evt");
    wr(CLR, 32'h0);
    rd(STAT, 32'h0000_0100, "t4_cleared");
    shoot_pulse();
    rd(STAT, 32'h0000_0001, "t4_one");
    shoot_in = 1'b1;
    wr(CLR, 32'h1);
    shoot_in = 1'b0;
    tick();
    rd(STAT, 32'h0000_0100, "t4_clear_wins");
    rd(EVT,  32'h0, "t4_clear_evt");

    // 5: irq
    do_reset("rst5");
    wr(CTRL, 32'h3);
    check("t5_irq_idle", {31'd0, bus.irq}, 32'd0);
    shoot_in = 1'b1;
    tick();
    shoot_in = 1'b0;
    check("t5_irq_rise", {31'd0, bus.irq}, 32'd1);
    rd(EVT, 32'hC000_0000, "t5_evt");
    check("t5_irq_fall", {31'd0, bus.irq}, 32'd0);
    wr(CTRL, 32'h1);
    shoot_pulse();
    check("t5_irq_masked", {31'd0, bus.irq}, 32'd0);
    rd(STAT, 32'h0000_0001, "t5_status");
    wr(CTRL, 32'h3);
    tick();
    check("t5_irq_unmask", {31'd0, bus.irq}, 32'd1);
    wr(CLR, 32'h0);
    check("t5_irq_clear", {31'd0, bus.irq}, 32'd0);

    // 6: enable with shoot already high, frame wrap, async reset during a read
    do_reset("rst6");
    shoot_in = 1'b1;
    repeat (3) tick();
    wr(CTRL, 32'h1);
    repeat (2) tick();
    rd(STAT, 32'h0000_0100, "t6_no_event_held");
    shoot_in = 1'b0; tick();
    shoot_in = 1'b1; tick();
    shoot_in = 1'b0;
    rd(STAT, 32'h0000_0001, "t6_new_edge");
    rd(EVT,  32'hC000_0000, "t6_evt");
    frames(3);
    rd(FRM, 32'h3, "t6_frame3");
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = FRM;
    #3 reset = 1'b1;
    #1;
    check("t6_async_rdata", bus.readdata, 32'd0);
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    reset = 1'b0;
    tick();
    check("t6_after_rst_rdata", bus.readdata, 32'd0);
    frames(65536);
    rd(FRM, 32'h0, "t6_frame_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
